fetch_pc_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_out_reg.sv | 43 ++++
 rtl/fetch_pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Defines the sequencer state encoding, reset PC default and PC step.
// Helper function flags fetch addresses that are not word aligned.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    TRAP = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  // True when an instruction address is not 4-byte aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Holding register for the instruction handed to decode (if_valid/if_pc/if_instr).
// Latency: data visible the cycle after load; clears valid the cycle after flush.
// Backpressure: contents held stable while if_valid && !if_ready.
module fetch_out_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  input  logic            flush,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  // Valid flag: flush beats load, load beats consumption by decode
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
    end else if (if_valid && if_ready) begin
      if_valid <= 1'b0;
    end
  end

  // Payload: only written on load so it stays stable while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc    <= '0;
      if_instr <= '0;
    end else if (load) begin
      if_pc    <= load_pc;
      if_instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: one outstanding imem request, response forwarded to decode; redirects squash in-flight data.
// Latency: request the cycle after IDLE/HOLD exit, decode output the cycle after the imem response.
// Backpressure: imem addr held while !imem_req_ready; no new fetch while decode holds if_valid && !if_ready.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps instead of fetching).
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            drop;
  logic            drop_next;
  logic            req_hs;
  logic            out_load;
  logic            out_flush;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = redirect_valid && is_misaligned(redirect_pc);
`else
  // Without the trap, low address bits of a redirect are simply ignored
  assign redirect_tgt = redirect_pc & PC_ALIGN_MASK;
  assign redirect_bad = 1'b0;
`endif

  assign req_hs        = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a redirect overrides the normal flow
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = REQ;
      REQ:     if (req_hs) next_state = WAIT;
      WAIT:    if (imem_rsp_valid) next_state = drop ? REQ : HOLD;
      HOLD:    if (if_ready) next_state = REQ;
      TRAP:    next_state = TRAP;
      default: next_state = IDLE;
    endcase
    if (redirect_valid) begin
      if (redirect_bad) begin
        next_state = TRAP;
      end else begin
        case (state)
          REQ:     next_state = req_hs ? WAIT : REQ;
          WAIT:    next_state = imem_rsp_valid ? REQ : WAIT;
          // A squashed response may still be owed; absorb it in WAIT first
          TRAP:    next_state = (drop && !imem_rsp_valid) ? WAIT : REQ;
          default: next_state = REQ;
        endcase
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    imem_req_valid = (state == REQ);
    out_load       = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;
    out_flush      = redirect_valid;
  end

  // Drop flag: at most one squashed response is ever owed
  always_comb begin
    drop_next = drop;
    if (imem_rsp_valid && (state == WAIT || state == TRAP)) begin
      drop_next = 1'b0;
    end
    if (redirect_valid &&
        ((state == REQ && req_hs) || (state == WAIT && !imem_rsp_valid))) begin
      drop_next = 1'b1;
    end
  end

  // PC, address of the request in flight, and drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      drop   <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_tgt;
      end else if (req_hs) begin
        pc <= pc + PC_INCR;
      end
      if (req_hs) begin
        req_pc <= pc;
      end
      drop <= drop_next;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Trap report: set by a misaligned redirect, cleared by the next good one
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else if (redirect_valid) begin
      misalign_trap <= redirect_bad;
      misalign_addr <= redirect_bad ? redirect_pc : '0;
    end
  end
`endif

  fetch_out_reg #(
    .XLEN(XLEN)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_pc   (req_pc),
    .load_instr(imem_rsp_data),
    .flush     (out_flush),
    .if_ready  (if_ready),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr)
  );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with an instruction memory responder.
// Memory answers a configurable number of cycles after each accepted request.
// Inputs and checks happen on the falling edge; logs are taken on the rising edge.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] ins_log[$];

  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = '0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  int          cnt = 0;
  int          rsp_lat = 1;

  fetch_pc_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Rising-edge observer: accepted requests and decode handshakes
  always @(posedge clk) begin
    hs_seen <= !reset && imem_req_valid && imem_req_ready;
    hs_addr <= imem_req_addr;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
      if (if_valid && if_ready) begin
        pc_log.push_back(if_pc);
        ins_log.push_back(if_instr);
      end
    end
  end

  // Memory responder: one response per accepted request, rsp_lat cycles later
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      imem_rsp_valid = 1'b0;
    end else begin
      if (hs_seen) begin
        pend  = 1'b1;
        paddr = hs_addr;
        cnt   = rsp_lat;
      end
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(paddr);
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
  end

  // Reset for two cycles, return in the IDLE cycle after release
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1; rsp_lat = 1;
    @(negedge clk);
    @(negedge clk);
    req_log.delete(); pc_log.delete(); ins_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_pc_log(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pc_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req_at(input logic [31:0] a, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_addr == a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_if_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (if_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_data pc=%h instr=%h exp=0/0", if_pc, if_instr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b0 || misalign_addr !== 32'h0) begin failures++; $display("FAIL reset_trap got=%b/%h exp=0/0", misalign_trap, misalign_addr); end
`endif
    reset = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_a[3] = '{32'h0, 32'h4, 32'h8};
    bit ok;
    do_reset();
    wait_pc_log(3, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL seq_timeout got=%0d exp=3 fetches", pc_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i] !== exp_a[i]) begin failures++; $display("FAIL seq_req%0d got=%h exp=%h", i, req_log[i], exp_a[i]); end
        checks++;
        if (pc_log[i] !== exp_a[i] || ins_log[i] !== instr_of(exp_a[i])) begin
          failures++; $display("FAIL seq_if%0d got=%h/%h exp=%h/%h", i, pc_log[i], ins_log[i], exp_a[i], instr_of(exp_a[i]));
        end
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    do_reset();
    if_ready = 1'b0;
    wait_if_valid(20, ok);
    checks++;
    if (!ok || if_pc !== 32'h0 || if_instr !== instr_of(32'h0)) begin
      failures++; $display("FAIL stall_first got=%b/%h/%h exp=1/00000000/%h", ok, if_pc, if_instr, instr_of(32'h0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== instr_of(32'h0) || imem_req_valid !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h req=%b exp 1/0/%h/0", i, if_valid, if_pc, if_instr, imem_req_valid, instr_of(32'h0));
      end
    end
    checks++;
    if (req_log.size() != 1) begin failures++; $display("FAIL stall_reqcount got=%0d exp=1", req_log.size()); end
    if_ready = 1'b1;
    wait_pc_log(2, 20, ok);
    checks++;
    if (!ok || req_log[1] !== 32'h4 || pc_log[1] !== 32'h4) begin failures++; $display("FAIL stall_resume got=%h/%h exp=4/4", req_log[1], pc_log[1]); end
  endtask

  task automatic test_redirect_inflight;
    bit ok;
    do_reset();
    wait_req_at(32'h8, 30, ok);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc_log(3, 30, ok);
    checks++;
    if (!ok || pc_log[0] !== 32'h0 || pc_log[1] !== 32'h4 || pc_log[2] !== 32'h100) begin
      failures++; $display("FAIL drop_ifseq got=%h,%h,%h exp=0,4,100", pc_log[0], pc_log[1], pc_log[2]);
    end
    checks++;
    if (req_log[2] !== 32'h8 || req_log[3] !== 32'h100) begin failures++; $display("FAIL drop_reqseq got=%h,%h exp=8,100", req_log[2], req_log[3]); end
    checks++;
    if (ins_log[2] !== instr_of(32'h100)) begin failures++; $display("FAIL drop_instr got=%h exp=%h", ins_log[2], instr_of(32'h100)); end
  endtask

  task automatic test_ready_low_redirect;
    bit ok;
    do_reset();
    imem_req_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin failures++; $display("FAIL rl_c1 got=%b/%h exp=1/20", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    checks++;
    if (imem_req_addr !== 32'h20) begin failures++; $display("FAIL rl_c2 got=%h exp=20", imem_req_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin failures++; $display("FAIL rl_c3 got=%b/%h exp=1/40", imem_req_valid, imem_req_addr); end
    checks++;
    if (req_log.size() != 0) begin failures++; $display("FAIL rl_noaccept got=%0d exp=0", req_log.size()); end
    imem_req_ready = 1'b1;
    wait_pc_log(1, 20, ok);
    checks++;
    if (!ok || req_log[0] !== 32'h40 || pc_log[0] !== 32'h40) begin failures++; $display("FAIL rl_fetch got=%h/%h exp=40/40", req_log[0], pc_log[0]); end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc_log(2, 30, ok);
    checks++;
    if (!ok || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_req got=%h,%h exp=fffffffc,0", req_log[0], req_log[1]); end
    checks++;
    if (pc_log[0] !== 32'hFFFF_FFFC || pc_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_if got=%h,%h exp=fffffffc,0", pc_log[0], pc_log[1]); end
  endtask

  task automatic test_hold_redirect;
    bit ok;
    do_reset();
    if_ready = 1'b0;
    wait_if_valid(20, ok);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (!ok || if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
      failures++; $display("FAIL hold_flush got v=%b req=%b/%h exp 0/1/300", if_valid, imem_req_valid, imem_req_addr);
    end
    if_ready = 1'b1;
    wait_pc_log(1, 20, ok);
    checks++;
    if (!ok || pc_log[0] !== 32'h300) begin failures++; $display("FAIL hold_next got=%h exp=300", pc_log[0]); end
  endtask

  task automatic test_wait_redirect;
    bit ok;
    do_reset();
    rsp_lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_log.size() >= 1) begin ok = 1'b1; break; end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc_log(1, 30, ok);
    checks++;
    if (!ok || pc_log[0] !== 32'h80 || ins_log[0] !== instr_of(32'h80)) begin
      failures++; $display("FAIL wait_drop got=%h/%h exp=80/%h", pc_log[0], ins_log[0], instr_of(32'h80));
    end
    checks++;
    if (req_log[1] !== 32'h80) begin failures++; $display("FAIL wait_nextreq got=%h exp=80", req_log[1]); end
    rsp_lat = 1;
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_trap;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (misalign_trap !== 1'b1 || misalign_addr !== 32'h102) begin failures++; $display("FAIL trap_set got=%b/%h exp=1/102", misalign_trap, misalign_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0 || misalign_trap !== 1'b1) begin failures++; $display("FAIL trap_hold%0d got req=%b trap=%b exp 0/1", i, imem_req_valid, misalign_trap); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (misalign_trap !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      failures++; $display("FAIL trap_exit got trap=%b req=%b/%h exp 0/1/200", misalign_trap, imem_req_valid, imem_req_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_ready_low_redirect();
    test_wrap();
    test_hold_redirect();
    test_wait_redirect();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_trap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
